// File: rtl/unified_buffer_write_control_unit.sv
// Write-side address generator for the unified buffer: turns accumulator row beats into
// registered write strobes/addresses laid out strip by strip with a tile-padded stride.
module unified_buffer_write_control_unit #(
    parameter int unsigned ADDR_W    = 12,
    parameter int unsigned DIM_W     = 9,
    parameter int unsigned TILE_LOG2 = 5
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              instruction_i,
    input  logic [DIM_W-1:0]  H_DIM_i,
    input  logic [DIM_W-1:0]  W_DIM_i,
    input  logic [ADDR_W-1:0] unified_buffer_start_addr_wr_i,
    input  logic              accumulator_valid_i,
    output logic              accumulator_ready_o,
    output logic              unified_buffer_write_en_o,
    output logic [ADDR_W-1:0] unified_buffer_addr_wr_o,
    output logic              busy_o,
    output logic              done_o
);

    localparam int unsigned SW = DIM_W - TILE_LOG2;

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] WRITE = 1'b1;

    logic [0:0]        state_q, state_d;
    logic [DIM_W-1:0]  h_dim_q, h_dim_d;
    logic [DIM_W:0]    stride_q, stride_d;
    logic [SW-1:0]     last_strip_q, last_strip_d;
    logic [DIM_W-1:0]  row_q, row_d;
    logic [SW-1:0]     strip_q, strip_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              done_q, done_d;

    logic              accept;
    logic [DIM_W:0]    h_ext;

    assign accept = (state_q == WRITE) && accumulator_valid_i;
    assign h_ext  = {1'b0, H_DIM_i};

    always_comb begin
        state_d      = state_q;
        h_dim_d      = h_dim_q;
        stride_d     = stride_q;
        last_strip_d = last_strip_q;
        row_d        = row_q;
        strip_d      = strip_q;
        base_d       = base_q;
        we_d         = 1'b0;
        addr_d       = addr_q;
        done_d       = 1'b0;

        case (state_q)
            IDLE: begin
                if (instruction_i) begin
                    h_dim_d      = H_DIM_i;
                    // Rows per strip rounded up to a whole tile so reads see the padded layout.
                    stride_d     = ((h_ext >> TILE_LOG2) + (DIM_W + 1)'(1)) << TILE_LOG2;
                    last_strip_d = SW'(W_DIM_i >> TILE_LOG2);
                    row_d        = '0;
                    strip_d      = '0;
                    base_d       = unified_buffer_start_addr_wr_i;
                    state_d      = WRITE;
                end
            end
            WRITE: begin
                if (accept) begin
                    we_d   = 1'b1;
                    addr_d = base_q + ADDR_W'(row_q);
                    if (row_q == h_dim_q) begin
                        row_d = '0;
                        if (strip_q == last_strip_q) begin
                            done_d  = 1'b1;
                            state_d = IDLE;
                        end else begin
                            strip_d = strip_q + SW'(1);
                            base_d  = base_q + ADDR_W'(stride_q);
                        end
                    end else begin
                        row_d = row_q + DIM_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q      <= IDLE;
            h_dim_q      <= '0;
            stride_q     <= '0;
            last_strip_q <= '0;
            row_q        <= '0;
            strip_q      <= '0;
            base_q       <= '0;
            we_q         <= 1'b0;
            addr_q       <= '0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            h_dim_q      <= h_dim_d;
            stride_q     <= stride_d;
            last_strip_q <= last_strip_d;
            row_q        <= row_d;
            strip_q      <= strip_d;
            base_q       <= base_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            done_q       <= done_d;
        end
    end

    assign accumulator_ready_o       = (state_q == WRITE);
    assign busy_o                    = (state_q == WRITE);
    assign unified_buffer_write_en_o = we_q;
    assign unified_buffer_addr_wr_o  = addr_q;
    assign done_o                    = done_q;

endmodule

// File: tb/tb_unified_buffer_write_control_unit.sv
// Directed bench for the unified buffer write controller; expected writes go through a
// scoreboard queue filled as beats are driven and drained as strobes appear.
module tb_unified_buffer_write_control_unit;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b0;
    logic        instruction_i = 1'b0;
    logic [8:0]  H_DIM_i = '0;
    logic [8:0]  W_DIM_i = '0;
    logic [11:0] start_i = '0;
    logic        valid_i = 1'b0;
    logic        ready_o, we_o, busy_o, done_o;
    logic [11:0] addr_o;

    unified_buffer_write_control_unit dut (
        .clk_i                         (clk_i),
        .rst_i                         (rst_i),
        .instruction_i                 (instruction_i),
        .H_DIM_i                       (H_DIM_i),
        .W_DIM_i                       (W_DIM_i),
        .unified_buffer_start_addr_wr_i(start_i),
        .accumulator_valid_i           (valid_i),
        .accumulator_ready_o           (ready_o),
        .unified_buffer_write_en_o     (we_o),
        .unified_buffer_addr_wr_o      (addr_o),
        .busy_o                        (busy_o),
        .done_o                        (done_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [11:0] addr;
        logic        done;
    } exp_t;

    exp_t        sb[$];
    int          n_checks = 0;
    int          n_pass   = 0;
    logic        model_busy = 1'b0;
    int          beat_k, total_beats, cur_start, cur_h, cur_stride;
    logic [11:0] last_addr = '0;

    task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got %0d, expected %0d", name, obs, exp);
    endtask

    // Called #1 after a rising edge; drives inputs, clocks once, then checks the outputs.
    task automatic cycle(input logic v, input logic instr);
        logic accepted, go;
        exp_t e;
        valid_i       = v;
        instruction_i = instr;
        check("ready", {31'd0, ready_o}, {31'd0, model_busy});
        check("busy", {31'd0, busy_o}, {31'd0, model_busy});
        accepted = model_busy && v;
        go       = !model_busy && instr;
        if (accepted) begin
            e.addr = 12'((cur_start + (beat_k / (cur_h + 1)) * cur_stride
                          + (beat_k % (cur_h + 1))) & 32'hFFF);
            e.done = (beat_k == total_beats - 1);
            sb.push_back(e);
            beat_k++;
        end
        @(posedge clk_i);
        #1;
        if (go) begin
            model_busy = 1'b1;
            beat_k     = 0;
        end
        if (accepted) begin
            e = sb.pop_front();
            if (e.done) model_busy = 1'b0;
            check("we", {31'd0, we_o}, 32'd1);
            check("addr", {20'd0, addr_o}, {20'd0, e.addr});
            check("done", {31'd0, done_o}, {31'd0, e.done});
            last_addr = e.addr;
        end else begin
            check("we_idle", {31'd0, we_o}, 32'd0);
            check("addr_hold", {20'd0, addr_o}, {20'd0, last_addr});
            check("done_idle", {31'd0, done_o}, 32'd0);
        end
    endtask

    task automatic start_job(input int s, input int h, input int w);
        H_DIM_i     = 9'(h);
        W_DIM_i     = 9'(w);
        start_i     = 12'(s);
        cur_start   = s;
        cur_h       = h;
        cur_stride  = ((h >> 5) + 1) << 5;
        total_beats = (h + 1) * ((w >> 5) + 1);
        cycle(1'b0, 1'b1);
        H_DIM_i = 9'h1AB;
        W_DIM_i = 9'h1CD;
        start_i = 12'hEEE;
    endtask

    task automatic check_all_zero(input string name);
        check({name, "_we"}, {31'd0, we_o}, 32'd0);
        check({name, "_addr"}, {20'd0, addr_o}, 32'd0);
        check({name, "_done"}, {31'd0, done_o}, 32'd0);
        check({name, "_ready"}, {31'd0, ready_o}, 32'd0);
        check({name, "_busy"}, {31'd0, busy_o}, 32'd0);
    endtask

    initial begin
        logic pat[7];
        pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

        // Reset state
        #2;
        check_all_zero("reset");
        @(posedge clk_i);
        #1;
        rst_i = 1'b1;

        // Valid in IDLE is ignored
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0);

        // Single tile: addrs 100..131
        start_job(100, 31, 31);
        for (int i = 0; i < 32; i++) cycle(1'b1, 1'b0);
        cycle(1'b0, 1'b0);

        // Two strips, stride 64, with an ignored mid-job instruction
        start_job(0, 40, 40);
        for (int i = 0; i < 82; i++) cycle(1'b1, (i == 20));
        // Instruction in the done cycle is accepted
        start_job(0, 3, 0);
        for (int i = 0; i < 7; i++) cycle(pat[i], 1'b0);
        cycle(1'b0, 1'b0);

        // Address wrap
        start_job(4090, 15, 0);
        for (int i = 0; i < 16; i++) cycle(1'b1, 1'b0);
        cycle(1'b0, 1'b0);

        // Reset mid-job
        start_job(300, 31, 31);
        for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0);
        rst_i = 1'b0;
        #2;
        check_all_zero("rst_mid");
        sb.delete();
        model_busy = 1'b0;
        last_addr  = '0;
        valid_i    = 1'b0;
        @(posedge clk_i);
        #1;
        rst_i = 1'b1;
        cycle(1'b1, 1'b0);
        start_job(200, 7, 0);
        for (int i = 0; i < 8; i++) cycle(1'b1, 1'b0);
        cycle(1'b0, 1'b0);

        check("sb_empty", sb.size(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/unified_buffer_write_control_unit.md
Name: unified_buffer_write_control_unit

Overview:
Write-side address controller for the unified buffer. It accepts row beats of result data from the accumulator stage, and generates the write enable and write address so that results land in the unified buffer tile-strip by tile-strip. Its address layout is the same padded layout the unified buffer read controller walks, so results can be read back directly as the next layer's activations. The data word itself is registered outside this block, with the same one-cycle delay as this block's outputs.

Parameters:
ADDR_W, 12, unified buffer address width
DIM_W, 9, width of the H/W dimension inputs
TILE_LOG2, 5, log2 of the tile edge (32)

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  reset, asynchronous, active-low
instruction_i  in  1  start pulse for one write job
H_DIM_i  in  DIM_W  last row index of the output matrix (rows 0..H_DIM_i)
W_DIM_i  in  DIM_W  last column index; strips = (W_DIM_i>>TILE_LOG2)+1
unified_buffer_start_addr_wr_i  in  ADDR_W  base address of the job
accumulator_valid_i  in  1  one result row-beat available this cycle
accumulator_ready_o  out  1  block accepts beats (state==WRITE)
unified_buffer_write_en_o  out  1  registered write strobe
unified_buffer_addr_wr_o  out  ADDR_W  registered write address
busy_o  out  1  job in progress
done_o  out  1  one-cycle pulse, job complete

Behaviour:
- Reset (rst_i low, any time, asynchronous) has these effects:
  - state=IDLE; row, strip and base counters are cleared.
  - All outputs are 0, including unified_buffer_addr_wr_o.
  - A job in flight is abandoned; no further writes occur.
- States are IDLE and WRITE.
- IDLE, on instruction_i=1 at a rising edge:
  - Latch H_DIM_i, W_DIM_i and the start address.
  - stride = ((H_DIM>>TILE_LOG2)+1)<<TILE_LOG2, computed at DIM_W+1 bits.
  - last_strip = W_DIM>>TILE_LOG2.
  - row=0, strip=0, base=start. Go to WRITE.
  - Inputs are not sampled again until the next job.
- accumulator_ready_o = (state==WRITE), decoded combinationally from the state register. Beat accepted = valid & ready.
- WRITE, per accepted beat:
  - Next edge: unified_buffer_write_en_o=1 and unified_buffer_addr_wr_o=base+row, both mod 2^ADDR_W.
  - Latency is exactly 1 cycle from acceptance to strobe.
  - Cycles without an accepted beat: write_en_o=0 and addr_wr_o holds its last value.
- Counter advance on each accepted beat:
  - If row==H_DIM: row=0, strip=strip+1, base=base+stride (adder only, no multiplier).
  - Otherwise: row=row+1.
- Final beat (row==H_DIM and strip==last_strip):
  - The same edge registers the last write, sets done_o=1 for exactly one cycle, and returns to IDLE.
  - Total beats = (H_DIM+1)*(last_strip+1).
- busy_o = (state==WRITE).
- instruction_i while in WRITE is ignored.
- instruction_i in the cycle done_o is high is accepted, because the state is already IDLE.
- accumulator_valid_i in IDLE is ignored: no write, no counter change.
- Address arithmetic wraps modulo 2^ADDR_W silently; there is no overflow flag.

Test Plan:
- Single tile: start=100, H=31, W=31, valid held high 32 cycles → addrs 100..131 on consecutive cycles, each one cycle after its beat; done_o high with the addr-131 write; busy_o low the cycle after.
- Two strips: start=0, H=40, W=40 → stride=64; 82 writes at addrs 0..40 then 64..104; done_o on addr 104.
- Bubbles: H=3, W=0, valid pattern 1,0,0,1,1,0,1 → write_en 1,0,0,1,1,0,1 delayed one cycle; addrs 0,(hold),(hold),1,2,(hold),3; done_o on addr 3.
- Wrap: start=4090, H=15, W=0 → addrs 4090..4095 then 0..9; done_o on addr 9.
- Ignored start / IDLE valid: pulse instruction_i mid-job → sequence unchanged. Valid in IDLE → no write_en.
- Reset mid-job: rst_i low after 5 writes → all outputs 0 immediately. New instruction_i after release → restarts at its own start address with row=0.
